// File: rtl/blocks_state_controller_pkg.sv
// Shared geometry, index widths and FSM encoding for the brick-wall block state.
// The geometry constants are common with the painter.
package blocks_state_controller_pkg;

  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS       = 16;
  localparam int BLOCK_WIDTH    = 48;
  localparam int BLOCK_HEIGHT   = 16;
  localparam int BORDER_WIDTH   = 8;

  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int CNT_W = 8;

  localparam int TOTAL_BLOCKS = NUM_ROWS * BLOCKS_PER_ROW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HIT_RD = 2'd2,
    ST_HIT_WR = 2'd3
  } state_e;

endpackage

// File: rtl/blocks_state_controller_if.sv
// Request bus between game logic (master) and the block state controller (slave).
// Optional macro BLOCKS_PATTERN_EN adds the fill_pattern field.
interface blocks_state_controller_if;
  import blocks_state_controller_pkg::*;

  logic             fill_req;
  logic             fill_busy;
  logic             hit_req;
  logic [ROW_W-1:0] hit_row;
  logic [COL_W-1:0] hit_col;
  logic             hit_ack;
  logic             hit_was_present;

`ifdef BLOCKS_PATTERN_EN
  logic [BLOCKS_PER_ROW-1:0] fill_pattern;

  modport master (
    output fill_req, fill_pattern, hit_req, hit_row, hit_col,
    input  fill_busy, hit_ack, hit_was_present
  );

  modport slave (
    input  fill_req, fill_pattern, hit_req, hit_row, hit_col,
    output fill_busy, hit_ack, hit_was_present
  );
`else
  modport master (
    output fill_req, hit_req, hit_row, hit_col,
    input  fill_busy, hit_ack, hit_was_present
  );

  modport slave (
    input  fill_req, hit_req, hit_row, hit_col,
    output fill_busy, hit_ack, hit_was_present
  );
`endif

endinterface

// File: rtl/blocks_state_controller_ram.sv
// Block presence storage: NUM_ROWS x BLOCKS_PER_ROW registers, one write port,
// asynchronous read ports for the display sequencer and the hit path.
module blocks_state_ram #(
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int ROW_W          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [ROW_W-1:0]          waddr_i,
  input  logic [BLOCKS_PER_ROW-1:0] wdata_i,
  input  logic [ROW_W-1:0]          disp_addr_i,
  output logic [BLOCKS_PER_ROW-1:0] disp_data_o,
  input  logic [ROW_W-1:0]          hit_addr_i,
  output logic [BLOCKS_PER_ROW-1:0] hit_data_o
);

  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(NUM_ROWS);

  logic [BLOCKS_PER_ROW-1:0] mem_q [NUM_ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && ({1'b0, waddr_i} < ROW_LIMIT)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past the last row read as an empty row.
  assign disp_data_o = ({1'b0, disp_addr_i} < ROW_LIMIT) ? mem_q[disp_addr_i] : '0;
  assign hit_data_o  = ({1'b0, hit_addr_i} < ROW_LIMIT) ? mem_q[hit_addr_i] : '0;

endmodule

// File: rtl/blocks_state_controller.sv
// Brick-wall state owner: display row sequencing, level fill, ball-hit removal, block count.
// Optional macro BLOCKS_PATTERN_EN: fill uses fill_pattern (odd rows rotated left by 1).
module blocks_state_controller #(
  parameter int BLOCKS_PER_ROW = blocks_state_controller_pkg::BLOCKS_PER_ROW,
  parameter int NUM_ROWS       = blocks_state_controller_pkg::NUM_ROWS,
  parameter int ROW_W          = blocks_state_controller_pkg::ROW_W,
  parameter int COL_W          = blocks_state_controller_pkg::COL_W,
  parameter int CNT_W          = blocks_state_controller_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  output logic [CNT_W-1:0]          blocks_remaining,
  output logic                      level_clear,
  blocks_state_controller_if.slave  bus
);
  import blocks_state_controller_pkg::*;

  localparam logic [ROW_W:0]          ROW_LIMIT = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [COL_W:0]          COL_LIMIT = (COL_W + 1)'(BLOCKS_PER_ROW);
  localparam logic [ROW_W-1:0]        LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [BLOCKS_PER_ROW-1:0] ONE_BIT = BLOCKS_PER_ROW'(1);

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          fill_idx_q, fill_idx_d;
  logic [ROW_W-1:0]          hit_row_q, hit_row_d;
  logic [COL_W-1:0]          hit_col_q, hit_col_d;
  logic [BLOCKS_PER_ROW-1:0] hit_word_q, hit_word_d;
  logic                      hit_bit_q, hit_bit_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ROW_W-1:0]          disp_row_q, disp_row_d;
  logic [BLOCKS_PER_ROW-1:0] line_q, line_d;

  logic                      we;
  logic [ROW_W-1:0]          waddr;
  logic [BLOCKS_PER_ROW-1:0] wdata;
  logic [BLOCKS_PER_ROW-1:0] disp_rd_data;
  logic [BLOCKS_PER_ROW-1:0] hit_rd_data;
  logic [BLOCKS_PER_ROW-1:0] fill_word;
  logic [CNT_W-1:0]          fill_count;
  logic                      hit_in_range;

  blocks_state_ram #(
    .BLOCKS_PER_ROW(BLOCKS_PER_ROW),
    .NUM_ROWS      (NUM_ROWS),
    .ROW_W         (ROW_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .disp_addr_i(disp_row_d),
    .disp_data_o(disp_rd_data),
    .hit_addr_i (bus.hit_row),
    .hit_data_o (hit_rd_data)
  );

`ifdef BLOCKS_PATTERN_EN
  logic [BLOCKS_PER_ROW-1:0] fill_pat_q, fill_pat_d;

  function automatic int pop_count(input logic [BLOCKS_PER_ROW-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  assign fill_word  = fill_idx_q[0] ? {fill_pat_q[BLOCKS_PER_ROW-2:0], fill_pat_q[BLOCKS_PER_ROW-1]}
                                    : fill_pat_q;
  assign fill_count = CNT_W'(NUM_ROWS * pop_count(bus.fill_pattern));
  assign fill_pat_d = (state_q == ST_IDLE && bus.fill_req) ? bus.fill_pattern : fill_pat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_pat_q <= '0;
    end else begin
      fill_pat_q <= fill_pat_d;
    end
  end
`else
  assign fill_word  = '1;
  assign fill_count = CNT_W'(NUM_ROWS * BLOCKS_PER_ROW);
`endif

  // The displayed line is reloaded only on a strobe, so writes never tear a line mid-paint.
  always_comb begin
    disp_row_d = disp_row_q;
    line_d     = line_q;
    if (new_frame) begin
      disp_row_d = '0;
    end else if (go_next_line) begin
      disp_row_d = (disp_row_q == LAST_ROW) ? '0 : disp_row_q + 1'b1;
    end
    if (new_frame || go_next_line) begin
      line_d = disp_rd_data;
    end
  end

  assign hit_in_range = ({1'b0, bus.hit_row} < ROW_LIMIT) && ({1'b0, bus.hit_col} < COL_LIMIT);

  always_comb begin
    state_d             = state_q;
    fill_idx_d          = fill_idx_q;
    hit_row_d           = hit_row_q;
    hit_col_d           = hit_col_q;
    hit_word_d          = hit_word_q;
    hit_bit_d           = hit_bit_q;
    count_d             = count_q;
    we                  = 1'b0;
    waddr               = fill_idx_q;
    wdata               = fill_word;
    level_clear         = 1'b0;
    bus.fill_busy       = 1'b0;
    bus.hit_ack         = 1'b0;
    bus.hit_was_present = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.fill_req) begin
          state_d    = ST_FILL;
          fill_idx_d = '0;
          count_d    = fill_count;
        end else if (bus.hit_req) begin
          state_d = ST_HIT_RD;
        end
      end
      ST_FILL: begin
        bus.fill_busy = 1'b1;
        we            = 1'b1;
        if (fill_idx_q == LAST_ROW) begin
          state_d = ST_IDLE;
        end else begin
          fill_idx_d = fill_idx_q + 1'b1;
        end
      end
      ST_HIT_RD: begin
        // An out-of-range hit is carried as an absent block, so it acks without any write.
        hit_row_d  = bus.hit_row;
        hit_col_d  = bus.hit_col;
        hit_word_d = hit_rd_data;
        hit_bit_d  = hit_in_range && (|(hit_rd_data & (ONE_BIT << bus.hit_col)));
        state_d    = ST_HIT_WR;
      end
      ST_HIT_WR: begin
        bus.hit_ack         = 1'b1;
        bus.hit_was_present = hit_bit_q;
        we                  = hit_bit_q;
        waddr               = hit_row_q;
        wdata               = hit_word_q & ~(ONE_BIT << hit_col_q);
        if (hit_bit_q && (count_q != '0)) begin
          count_d     = count_q - 1'b1;
          level_clear = (count_q == CNT_W'(1));
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_idx_q <= '0;
      hit_row_q  <= '0;
      hit_col_q  <= '0;
      hit_word_q <= '0;
      hit_bit_q  <= 1'b0;
      count_q    <= '0;
      disp_row_q <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      hit_row_q  <= hit_row_d;
      hit_col_q  <= hit_col_d;
      hit_word_q <= hit_word_d;
      hit_bit_q  <= hit_bit_d;
      count_q    <= count_d;
      disp_row_q <= disp_row_d;
      line_q     <= line_d;
    end
  end

  assign block_line_state = line_q;
  assign blocks_remaining = count_q;

endmodule

// File: tb/tb_blocks_state_controller.sv
// Directed bench for blocks_state_controller: a wall model plus a queue of expected hit results.
// Also exercises the BLOCKS_PATTERN_EN fill when that macro is defined.
module tb_blocks_state_controller;
  import blocks_state_controller_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      new_frame;
  logic                      go_next_line;
  logic [BLOCKS_PER_ROW-1:0] block_line_state;
  logic [CNT_W-1:0]          blocks_remaining;
  logic                      level_clear;

  blocks_state_controller_if bus ();

  blocks_state_controller dut (
    .clk             (clk),
    .rst             (rst),
    .new_frame       (new_frame),
    .go_next_line    (go_next_line),
    .block_line_state(block_line_state),
    .blocks_remaining(blocks_remaining),
    .level_clear     (level_clear),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  logic [BLOCKS_PER_ROW-1:0] model [NUM_ROWS];
  logic [BLOCKS_PER_ROW-1:0] fillPattern;
  logic [BLOCKS_PER_ROW-1:0] expLine;
  logic                      expQ [$];
  int                        modelCount;
  int                        dispRow;
  int                        checks = 0;
  int                        errors = 0;
  int                        lcPulses = 0;

  always @(negedge clk) begin
    if (level_clear === 1'b1) lcPulses++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelFill();
    logic [BLOCKS_PER_ROW-1:0] rot;
    rot = {fillPattern[BLOCKS_PER_ROW-2:0], fillPattern[BLOCKS_PER_ROW-1]};
    for (int r = 0; r < NUM_ROWS; r++) begin
      model[r] = r[0] ? rot : fillPattern;
    end
    modelCount = NUM_ROWS * $countones(fillPattern);
  endtask

  // Display strobe: one cycle of new_frame/go_next_line, then the loaded line is compared.
  task automatic applyStimulus(input logic nf, input logic gnl);
    if (nf) dispRow = 0;
    else if (gnl) dispRow = (dispRow + 1) % NUM_ROWS;
    if (nf || gnl) expLine = model[dispRow];
    new_frame    = nf;
    go_next_line = gnl;
    @(negedge clk);
    new_frame    = 1'b0;
    go_next_line = 1'b0;
    checkOutput("block_line_state", block_line_state, expLine);
  endtask

  task automatic doFill();
    int n;
    bus.fill_req = 1'b1;
    @(negedge clk);
    bus.fill_req = 1'b0;
    n = 0;
    while (bus.fill_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    modelFill();
    checkOutput("fill_busy_cycles", n, NUM_ROWS);
    checkOutput("blocks_remaining_after_fill", blocks_remaining, modelCount);
  endtask

  task automatic doHit(input int r, input int c, input logic withFill, input int expLat);
    logic exp;
    logic expClear;
    logic gotAck;
    int   cycles;
    if (withFill) modelFill();
    exp = 1'b0;
    if (r < NUM_ROWS && c < BLOCKS_PER_ROW) exp = model[r][c];
    if (exp) begin
      model[r][c] = 1'b0;
      modelCount--;
    end
    expClear = exp && (modelCount == 0);
    expQ.push_back(exp);
    bus.hit_req  = 1'b1;
    bus.hit_row  = ROW_W'(r);
    bus.hit_col  = COL_W'(c);
    bus.fill_req = withFill;
    cycles = 0;
    gotAck = 1'b0;
    while (!gotAck && cycles < 64) begin
      @(negedge clk);
      cycles++;
      bus.fill_req = 1'b0;
      if (bus.hit_ack === 1'b1) gotAck = 1'b1;
    end
    bus.hit_req = 1'b0;
    checkOutput("hit_ack_seen", gotAck, 1'b1);
    if (gotAck) begin
      if (expLat > 0) checkOutput("hit_latency", cycles, expLat);
      checkOutput("hit_was_present", bus.hit_was_present, expQ.pop_front());
      checkOutput("level_clear_at_ack", level_clear, expClear);
    end else begin
      void'(expQ.pop_front());
    end
    @(negedge clk);
    checkOutput("hit_ack_pulse", bus.hit_ack, 1'b0);
    checkOutput("blocks_remaining", blocks_remaining, modelCount);
  endtask

  initial begin
    rst              = 1'b1;
    new_frame        = 1'b0;
    go_next_line     = 1'b0;
    bus.fill_req     = 1'b0;
    bus.hit_req      = 1'b0;
    bus.hit_row      = '0;
    bus.hit_col      = '0;
    fillPattern      = '1;
`ifdef BLOCKS_PATTERN_EN
    bus.fill_pattern = fillPattern;
`endif
    for (int r = 0; r < NUM_ROWS; r++) model[r] = '0;
    modelCount = 0;
    dispRow    = 0;
    expLine    = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_line", block_line_state, 0);
    checkOutput("reset_fill_busy", bus.fill_busy, 0);
    checkOutput("reset_hit_ack", bus.hit_ack, 0);
    checkOutput("reset_was_present", bus.hit_was_present, 0);
    checkOutput("reset_level_clear", level_clear, 0);
    checkOutput("reset_count", blocks_remaining, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] fill and first frame");
    doFill();
    checkOutput("count_total", blocks_remaining, TOTAL_BLOCKS);
    applyStimulus(1'b1, 1'b0);
    checkOutput("row0_full", block_line_state, 13'h1FFF);

    $display("[TB] hit row 3 col 5, then repeat");
    doHit(3, 5, 1'b0, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("row3_after_hit", block_line_state, 13'h1FDF);
    doHit(3, 5, 1'b0, 2);

    $display("[TB] hit on displayed row");
    applyStimulus(1'b1, 1'b0);
    doHit(0, 0, 1'b0, 2);
    checkOutput("line_hold", block_line_state, 13'h1FFF);
    applyStimulus(1'b1, 1'b0);
    checkOutput("row0_after_frame", block_line_state, 13'h1FFE);

    $display("[TB] new_frame wins over go_next_line, and row wrap");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < NUM_ROWS; i++) applyStimulus(1'b0, 1'b1);

    $display("[TB] simultaneous fill and hit, out-of-range hits");
    doHit(2, 4, 1'b1, NUM_ROWS + 3);
    doHit(1, 13, 1'b0, 2);
    doHit(5, 15, 1'b0, 2);

    $display("[TB] clear the wall");
    lcPulses = 0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < BLOCKS_PER_ROW; c++) begin
        doHit(r, c, 1'b0, 2);
      end
    end
    checkOutput("level_clear_pulses", lcPulses, 1);
    checkOutput("count_zero", blocks_remaining, 0);
    doHit(7, 7, 1'b0, 2);
    checkOutput("no_underflow", blocks_remaining, 0);

    $display("[TB] reset during fill");
    bus.fill_req = 1'b1;
    @(negedge clk);
    bus.fill_req = 1'b0;
    @(negedge clk);
    modelFill();
    applyStimulus(1'b1, 1'b0);
    checkOutput("fill_busy_mid", bus.fill_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_fill_busy", bus.fill_busy, 0);
    checkOutput("rst_line", block_line_state, 0);
    checkOutput("rst_count", blocks_remaining, 0);
    checkOutput("rst_hit_ack", bus.hit_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) model[r] = '0;
    modelCount = 0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_storage_row0", block_line_state, 0);

`ifdef BLOCKS_PATTERN_EN
    $display("[TB] pattern fill");
    fillPattern      = 13'h1555;
    bus.fill_pattern = fillPattern;
    doFill();
    checkOutput("pattern_count", blocks_remaining, 112);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pattern_even", block_line_state, 13'h1555);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pattern_odd", block_line_state, 13'h0AAB);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
